// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// Holds the state enum, mux select codes and op-class constants.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] RD_PC = 4'd15;

   // States that stall on MemReady and feed the wait timer.
   function automatic logic is_wait_state(state_t s);
      return s inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR fields and status in, strobes out.
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if;

   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       CondEx;
   logic       MemReady;

   logic       PCEn;
   logic       PCSrc;
   logic       IRWrite;
   logic       AdrSrc;
   logic       MemW;
   logic       RegW;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       ALUOp;
   logic       IllegalOp;
   logic       BusError;
   logic       InstrDone;

   modport master (
      input  Op, Funct, Rd, CondEx, MemReady,
      output PCEn, PCSrc, IRWrite, AdrSrc, MemW, RegW,
      output ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
      output IllegalOp, BusError, InstrDone
   );

   modport slave (
      output Op, Funct, Rd, CondEx, MemReady,
      input  PCEn, PCSrc, IRWrite, AdrSrc, MemW, RegW,
      input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
      input  IllegalOp, BusError, InstrDone
   );

endinterface

// File: rtl/multicycle_control_fsm_wait_timer.sv
// Saturating 8-bit MemReady wait counter with terminal-count flag.
// Ports: CLK, Reset, wait_en (stalled this cycle), clr, tc.
module ctrl_wait_timer #(
   parameter int unsigned MAX = 15
) (
   input  logic CLK,
   input  logic Reset,
   input  logic wait_en,
   input  logic clr,
   output logic tc
);

   logic [7:0] cnt;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (wait_en && cnt != 8'hFF)
         cnt <= cnt + 8'd1;
   end

   // Flags the stall cycle that would bring the count up to MAX,
   // so the controller can leave for HALT on that same edge.
   assign tc = wait_en && (({1'b0, cnt} + 9'd1) == 9'(MAX));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle core sequencer: fetch/decode/execute/mem/writeback control.
// Ports: CLK, Reset (async, high), bus (master modport of the ctrl bundle).
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned FETCH_WAIT_MAX = 15
) (
   input  logic                         CLK,
   input  logic                         Reset,
   multicycle_control_fsm_if.master     bus
);

   state_t state;
   state_t next;

   logic ready;
   logic wait_en;
   logic tc;
   logic bus_err;

   logic       pc_en;
   logic       pc_src;
   logic       ir_write;
   logic       adr_src;
   logic       mem_w;
   logic       reg_w;
   logic       src_a;
   logic [1:0] src_b;
   logic [1:0] res_src;
   logic       alu_op;
   logic       illegal;
   logic       wb_cond;

   logic unused_funct;
   assign unused_funct = ^bus.Funct[2:1];

   assign ready   = bus.MemReady;
   assign wait_en = is_wait_state(state) && !ready;

   ctrl_wait_timer #(
      .MAX (FETCH_WAIT_MAX)
   ) u_wait (
      .CLK     (CLK),
      .Reset   (Reset),
      .wait_en (wait_en),
      .clr     (ready || (next != state)),
      .tc      (tc)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= S_FETCH;
         bus_err <= 1'b0;
      end else begin
         state <= next;
         if (tc)
            bus_err <= 1'b1;
      end
   end

   always_comb begin
      next = state;
      case (state)
         S_FETCH: begin
            if (tc)
               next = S_HALT;
            else if (ready)
               next = S_DECODE;
         end
         S_DECODE: begin
            case (bus.Op)
               OP_DP:   next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_MEM:  next = S_MEMADR;
               OP_BR:   next = S_BRANCH;
               default: next = S_FETCH;
            endcase
         end
         S_MEMADR:
            next = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (tc)
               next = S_HALT;
            else if (ready)
               next = S_MEMWB;
         end
         S_MEMWRITE: begin
            if (tc)
               next = S_HALT;
            else if (ready)
               next = S_FETCH;
         end
         S_EXECUTER, S_EXECUTEI:
            next = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BRANCH:
            next = S_FETCH;
         S_HALT:
            next = S_HALT;
         default:
            next = S_FETCH;
      endcase
   end

   always_comb begin
      pc_en    = 1'b0;
      pc_src   = 1'b0;
      ir_write = 1'b0;
      adr_src  = 1'b0;
      mem_w    = 1'b0;
      reg_w    = 1'b0;
      src_a    = 1'b0;
      src_b    = SRCB_REG;
      res_src  = RES_ALUOUT;
      alu_op   = 1'b0;
      illegal  = 1'b0;
      wb_cond  = 1'b0;
      case (state)
         S_FETCH: begin
            src_a    = 1'b1;
            src_b    = SRCB_FOUR;
            res_src  = RES_ALU;
            ir_write = ready;
            pc_en    = ready;
         end
         S_DECODE: begin
            src_a   = 1'b1;
            src_b   = SRCB_FOUR;
            res_src = RES_ALU;
            illegal = (bus.Op == OP_ILL);
         end
         S_MEMADR: begin
            src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_w   = bus.CondEx;
         end
         S_MEMWB: begin
            res_src = RES_DATA;
            wb_cond = bus.CondEx;
         end
         S_EXECUTER: begin
            alu_op = 1'b1;
         end
         S_EXECUTEI: begin
            src_b  = SRCB_IMM;
            alu_op = 1'b1;
         end
         S_ALUWB: begin
            // cmd 10xx are compare/test ops: flags only, no write.
            wb_cond = bus.CondEx && (bus.Funct[4:3] != 2'b10);
         end
         S_BRANCH: begin
            src_b   = SRCB_IMM;
            res_src = RES_ALU;
            pc_en   = bus.CondEx;
            pc_src  = bus.CondEx;
         end
         default: begin
         end
      endcase
      // A write to r15 is redirected into the PC through Result.
      if (wb_cond && bus.Rd == RD_PC) begin
         pc_en  = 1'b1;
         pc_src = 1'b1;
      end else if (wb_cond) begin
         reg_w = 1'b1;
      end
   end

   assign bus.PCEn      = pc_en && !Reset;
   assign bus.PCSrc     = pc_src && !Reset;
   assign bus.IRWrite   = ir_write && !Reset;
   assign bus.AdrSrc    = adr_src;
   assign bus.MemW      = mem_w && !Reset;
   assign bus.RegW      = reg_w && !Reset;
   assign bus.ALUSrcA   = src_a;
   assign bus.ALUSrcB   = src_b;
   assign bus.ResultSrc = res_src;
   assign bus.ALUOp     = alu_op;
   assign bus.IllegalOp = illegal && !Reset;
   assign bus.BusError  = bus_err;
   assign bus.InstrDone = (state != S_FETCH) && (next == S_FETCH) && !Reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with an expected-output queue.
// Each step drives inputs, queues the expected strobe vector, then checks.
module tb_multicycle_control_fsm;

   logic CLK = 1'b0;
   logic Reset;

   int total = 0;
   int bad   = 0;

   logic [14:0] sb_q[$];
   string       tag_q[$];

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm #(
      .FETCH_WAIT_MAX (15)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Vector: PCEn PCSrc IRWrite AdrSrc MemW RegW ALUSrcA ALUSrcB
   //         ResultSrc ALUOp IllegalOp BusError InstrDone
   function automatic logic [14:0] mk(
      input logic pe, ps, irw, adr, mw, rw, sa,
      input logic [1:0] sb, rs,
      input logic ao, il, be, dn
   );
      return {pe, ps, irw, adr, mw, rw, sa, sb, rs, ao, il, be, dn};
   endfunction

   function automatic logic [14:0] observed();
      return {bus.PCEn, bus.PCSrc, bus.IRWrite, bus.AdrSrc, bus.MemW,
              bus.RegW, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
              bus.ALUOp, bus.IllegalOp, bus.BusError, bus.InstrDone};
   endfunction

   // Called just after a falling edge; checks before the next rising edge.
   task automatic step(input string tag, input logic mr,
                       input logic [14:0] exp);
      logic [14:0] got;
      logic [14:0] e;
      string       t;
      bus.MemReady = mr;
      sb_q.push_back(exp);
      tag_q.push_back(tag);
      #1;
      got = observed();
      e   = sb_q.pop_front();
      t   = tag_q.pop_front();
      total++;
      assert (got === e) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b", t, got, e);
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic instr(input logic [1:0] op, input logic [5:0] fn,
                        input logic [3:0] rd, input logic ce);
      bus.Op     = op;
      bus.Funct  = fn;
      bus.Rd     = rd;
      bus.CondEx = ce;
   endtask

   logic [14:0] rst_v, f_rdy, f_wt, dec, dec_ill;
   logic [14:0] exr, exi, wb_reg, wb_pc, wb_none;
   logic [14:0] madr, mrd, mwb, mwr_w0, mwr_d0, mwr_w1, mwr_d1;
   logic [14:0] br_nt, br_t, halt;

   initial begin
      rst_v   = mk(0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,0);
      f_rdy   = mk(1,0,1,0,0,0,1,2'b10,2'b10,0,0,0,0);
      f_wt    = mk(0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,0);
      dec     = mk(0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,0);
      dec_ill = mk(0,0,0,0,0,0,1,2'b10,2'b10,0,1,0,1);
      exr     = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,0,0);
      exi     = mk(0,0,0,0,0,0,0,2'b01,2'b00,1,0,0,0);
      wb_reg  = mk(0,0,0,0,0,1,0,2'b00,2'b00,0,0,0,1);
      wb_pc   = mk(1,1,0,0,0,0,0,2'b00,2'b00,0,0,0,1);
      wb_none = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,0,1);
      madr    = mk(0,0,0,0,0,0,0,2'b01,2'b00,0,0,0,0);
      mrd     = mk(0,0,0,1,0,0,0,2'b00,2'b00,0,0,0,0);
      mwb     = mk(0,0,0,0,0,1,0,2'b00,2'b01,0,0,0,1);
      mwr_w0  = mk(0,0,0,1,0,0,0,2'b00,2'b00,0,0,0,0);
      mwr_d0  = mk(0,0,0,1,0,0,0,2'b00,2'b00,0,0,0,1);
      mwr_w1  = mk(0,0,0,1,1,0,0,2'b00,2'b00,0,0,0,0);
      mwr_d1  = mk(0,0,0,1,1,0,0,2'b00,2'b00,0,0,0,1);
      br_nt   = mk(0,0,0,0,0,0,0,2'b01,2'b10,0,0,0,1);
      br_t    = mk(1,1,0,0,0,0,0,2'b01,2'b10,0,0,0,1);
      halt    = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,0);

      Reset        = 1'b1;
      bus.MemReady = 1'b1;
      instr(2'b00, 6'b000100, 4'd2, 1'b1);
      @(negedge CLK);

      for (int i = 0; i < 3; i++)
         step("reset_hold", 1'b1, rst_v);
      Reset = 1'b0;

      // ADD r2: FETCH, DECODE, EXECUTER, ALUWB
      step("add_fetch", 1'b1, f_rdy);
      step("add_decode", 1'b1, dec);
      step("add_exec", 1'b1, exr);
      step("add_wb", 1'b1, wb_reg);

      // ADDI to r15: PC written through Result
      instr(2'b00, 6'b100100, 4'd15, 1'b1);
      step("addi_pc_fetch", 1'b1, f_rdy);
      step("addi_pc_decode", 1'b1, dec);
      step("addi_pc_exec", 1'b1, exi);
      step("addi_pc_wb", 1'b1, wb_pc);

      // LDR with three stall cycles in MEMREAD
      instr(2'b01, 6'b011001, 4'd3, 1'b1);
      step("ldr_fetch", 1'b1, f_rdy);
      step("ldr_decode", 1'b1, dec);
      step("ldr_adr", 1'b1, madr);
      for (int i = 0; i < 3; i++)
         step("ldr_read_wait", 1'b0, mrd);
      step("ldr_read_done", 1'b1, mrd);
      step("ldr_wb", 1'b1, mwb);

      // Branch not taken, then taken
      instr(2'b10, 6'b000000, 4'd0, 1'b0);
      step("bnt_fetch", 1'b1, f_rdy);
      step("bnt_decode", 1'b1, dec);
      step("bnt_branch", 1'b1, br_nt);
      instr(2'b10, 6'b000000, 4'd0, 1'b1);
      step("bt_fetch", 1'b1, f_rdy);
      step("bt_decode", 1'b1, dec);
      step("bt_branch", 1'b1, br_t);

      // CMP: compare op, no register write
      instr(2'b00, 6'b010101, 4'd2, 1'b1);
      step("cmp_fetch", 1'b1, f_rdy);
      step("cmp_decode", 1'b1, dec);
      step("cmp_exec", 1'b1, exr);
      step("cmp_wb", 1'b1, wb_none);

      // STR with CondEx=0: no MemW while stalled or completing
      instr(2'b01, 6'b011000, 4'd4, 1'b0);
      step("str_nc_fetch", 1'b1, f_rdy);
      step("str_nc_decode", 1'b1, dec);
      step("str_nc_adr", 1'b1, madr);
      step("str_nc_wait", 1'b0, mwr_w0);
      step("str_nc_done", 1'b1, mwr_d0);

      // STR with CondEx=1: MemW held every cycle in MEMWRITE
      instr(2'b01, 6'b011000, 4'd4, 1'b1);
      step("str_c_fetch", 1'b1, f_rdy);
      step("str_c_decode", 1'b1, dec);
      step("str_c_adr", 1'b1, madr);
      step("str_c_wait", 1'b0, mwr_w1);
      step("str_c_done", 1'b1, mwr_d1);

      // Illegal op: one-cycle pulse and straight back to FETCH
      instr(2'b11, 6'b000000, 4'd0, 1'b1);
      step("ill_fetch", 1'b1, f_rdy);
      step("ill_decode", 1'b1, dec_ill);

      // 14 stalls is one short of the limit: fetch still completes
      for (int i = 0; i < 14; i++)
         step("fetch14_wait", 1'b0, f_wt);
      step("fetch14_done", 1'b1, f_rdy);
      step("fetch14_decode", 1'b1, dec_ill);

      // 15 stalls trips BusError and parks in HALT
      for (int i = 0; i < 15; i++)
         step("fetch15_wait", 1'b0, f_wt);
      step("halt_lo", 1'b0, halt);
      step("halt_hi", 1'b1, halt);
      step("halt_stay", 1'b1, halt);

      // Reset raised mid-cycle acts without a clock edge
      Reset = 1'b1;
      step("halt_async_rst", 1'b1, rst_v);
      Reset = 1'b0;
      step("post_rst_fetch", 1'b1, f_rdy);
      step("post_rst_decode", 1'b1, dec_ill);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
